load_store_unit: RTL and testbench

//  MEM-stage initiator for data memory: accepts one load/store per handshake from the pipeline.

---
 rtl/rv_mem_pkg.sv | 47 ++++
 rtl/lsu_align.sv | 49 ++++
 rtl/load_store_unit.sv | 143 ++++++++++++++
 tb/tb_load_store_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory path: funct3 codes, access-size helpers
// and the load/store unit state encoding.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE0 = 3'd1,
    ST_WAIT0  = 3'd2,
    ST_ISSUE1 = 3'd3,
    ST_WAIT1  = 3'd4,
    ST_RESP   = 3'd5
  } lsu_state_e;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  // True when the access crosses into the next memory word.
  function automatic logic spans_words(input logic [1:0] sz, input logic [1:0] off);
    spans_words = ({1'b0, off} + size_bytes(sz)) > 3'd4;
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3, input logic wr);
    if (wr) f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data/byte-enable placement over two words,
// and load merge of two returned words followed by sign/zero extension.
module lsu_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic        spans_o,
  output logic [3:0]  be0_o,
  output logic [3:0]  be1_o,
  output logic [31:0] wdata0_o,
  output logic [31:0] wdata1_o,
  output logic [31:0] ldata_o
);

  logic [3:0]  mask;
  logic [7:0]  be8;
  logic [31:0] lane_mask;
  logic [63:0] wwide;
  logic [63:0] merged;
  logic [4:0]  shamt;

  always_comb begin
    mask      = size_mask(funct3_i[1:0]);
    spans_o   = spans_words(funct3_i[1:0], off_i);
    be8       = {4'b0000, mask} << off_i;
    be0_o     = be8[3:0];
    be1_o     = be8[7:4];
    shamt     = {off_i, 3'b000};
    // Bytes beyond the access size are zeroed so disabled lanes carry 0.
    lane_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    wwide     = {32'h0, wdata_i & lane_mask} << shamt;
    wdata0_o  = wwide[31:0];
    wdata1_o  = wwide[63:32];
    merged    = {hi_i, lo_i} >> shamt;
    case (funct3_i)
      F3_B:    ldata_o = {{24{merged[7]}}, merged[7:0]};
      F3_H:    ldata_o = {{16{merged[15]}}, merged[15:0]};
      F3_W:    ldata_o = merged[31:0];
      F3_BU:   ldata_o = {24'h0, merged[7:0]};
      F3_HU:   ldata_o = {16'h0, merged[15:0]};
      default: ldata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: one outstanding access, word-granular memory
// requests, misaligned accesses split into two word transactions.
module load_store_unit
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_I,
  output logic              req_ready_O,
  input  logic              req_write_I,
  input  logic [2:0]        funct3_I,
  input  logic [ADDR_W-1:0] addr_I,
  input  logic [31:0]       wdata_I,
  output logic              resp_valid_O,
  output logic [31:0]       resp_rdata_O,
  output logic              resp_err_O,
  output logic              mem_req_O,
  output logic              mem_we_O,
  output logic [ADDR_W-3:0] mem_addr_O,
  output logic [3:0]        mem_be_O,
  output logic [31:0]       mem_wdata_O,
  input  logic              mem_gnt_I,
  input  logic              mem_rvalid_I,
  input  logic [31:0]       mem_rdata_I
);

  localparam logic [ADDR_W-3:0] WORD_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              err_q;
  logic [31:0]       lo_q, hi_q;

  logic              accept;
  logic              req_bad;
  logic              spans;
  logic [3:0]        be0, be1;
  logic [31:0]       wdata0, wdata1, ldata;

  // With splitting disabled, any access that would need two words is refused.
  assign req_bad = !f3_legal(funct3_I, req_write_I) ||
                   (!ALLOW_MISALIGNED && spans_words(funct3_I[1:0], addr_I[1:0]));
  assign accept  = (state_q == ST_IDLE) && req_valid_I;

  lsu_align u_align (
    .funct3_i (f3_q),
    .off_i    (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .lo_i     (lo_q),
    .hi_i     (hi_q),
    .spans_o  (spans),
    .be0_o    (be0),
    .be1_o    (be1),
    .wdata0_o (wdata0),
    .wdata1_o (wdata1),
    .ldata_o  (ldata)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid_I) state_d = req_bad ? ST_RESP : ST_ISSUE0;
      ST_ISSUE0: if (mem_gnt_I) state_d = ST_WAIT0;
      ST_WAIT0:  if (mem_rvalid_I) state_d = spans ? ST_ISSUE1 : ST_RESP;
      ST_ISSUE1: if (mem_gnt_I) state_d = ST_WAIT1;
      ST_WAIT1:  if (mem_rvalid_I) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request capture and returned-word staging; hi_q stays 0 for single-word loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      f3_q    <= 3'b000;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= 32'h0;
      hi_q    <= 32'h0;
    end else begin
      if (accept) begin
        addr_q  <= addr_I;
        f3_q    <= funct3_I;
        wdata_q <= wdata_I;
        we_q    <= req_write_I;
        err_q   <= req_bad;
        lo_q    <= 32'h0;
        hi_q    <= 32'h0;
      end
      if ((state_q == ST_WAIT0) && mem_rvalid_I) lo_q <= mem_rdata_I;
      if ((state_q == ST_WAIT1) && mem_rvalid_I) hi_q <= mem_rdata_I;
    end
  end

  always_comb begin
    req_ready_O  = 1'b0;
    resp_valid_O = 1'b0;
    resp_rdata_O = 32'h0;
    resp_err_O   = 1'b0;
    mem_req_O    = 1'b0;
    mem_we_O     = 1'b0;
    mem_addr_O   = '0;
    mem_be_O     = 4'b0000;
    mem_wdata_O  = 32'h0;
    case (state_q)
      ST_IDLE: req_ready_O = 1'b1;
      ST_ISSUE0: begin
        mem_req_O   = 1'b1;
        mem_we_O    = we_q;
        mem_addr_O  = addr_q[ADDR_W-1:2];
        mem_be_O    = be0;
        mem_wdata_O = we_q ? wdata0 : 32'h0;
      end
      ST_ISSUE1: begin
        mem_req_O   = 1'b1;
        mem_we_O    = we_q;
        mem_addr_O  = addr_q[ADDR_W-1:2] + WORD_ONE;
        mem_be_O    = be1;
        mem_wdata_O = we_q ? wdata1 : 32'h0;
      end
      ST_RESP: begin
        resp_valid_O = 1'b1;
        resp_err_O   = err_q;
        resp_rdata_O = (err_q || we_q) ? 32'h0 : ldata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-enable memory model.
module tb_load_store_unit;
  import rv_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        gnt_en = 1'b1;
  logic        mrvalid;
  logic [31:0] mrdata;

  load_store_unit #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid_I(req_valid), .req_ready_O(req_ready), .req_write_I(req_write),
    .funct3_I(f3), .addr_I(addr), .wdata_I(wdata),
    .resp_valid_O(resp_valid), .resp_rdata_O(resp_rdata), .resp_err_O(resp_err),
    .mem_req_O(mem_req), .mem_we_O(mem_we), .mem_addr_O(mem_addr), .mem_be_O(mem_be),
    .mem_wdata_O(mem_wdata), .mem_gnt_I(gnt_en), .mem_rvalid_I(mrvalid), .mem_rdata_I(mrdata)
  );

  // Second instance with splitting disabled; its memory side never answers.
  logic        na_valid = 1'b0;
  logic [2:0]  na_f3 = 3'b000;
  logic [31:0] na_addr = 32'h0;
  logic        na_ready, na_rvalid, na_err, na_mreq, na_mwe;
  logic [31:0] na_rdata, na_mwdata;
  logic [29:0] na_maddr;
  logic [3:0]  na_mbe;

  load_store_unit #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut_na (
    .clk(clk), .rst(rst),
    .req_valid_I(na_valid), .req_ready_O(na_ready), .req_write_I(1'b0),
    .funct3_I(na_f3), .addr_I(na_addr), .wdata_I(32'h0),
    .resp_valid_O(na_rvalid), .resp_rdata_O(na_rdata), .resp_err_O(na_err),
    .mem_req_O(na_mreq), .mem_we_O(na_mwe), .mem_addr_O(na_maddr), .mem_be_O(na_mbe),
    .mem_wdata_O(na_mwdata), .mem_gnt_I(1'b0), .mem_rvalid_I(1'b0), .mem_rdata_I(32'h0)
  );

  // Memory model: 256 words indexed by low word-address bits, rvalid dly cycles after grant.
  logic [31:0] mem [0:255];
  bit          rnd_dly = 1'b0;
  int unsigned fix_dly = 1;
  int unsigned nxt_dly = 1;
  int unsigned pend_q = 0;
  logic [31:0] pend_d = 32'h0;

  always @(negedge clk) nxt_dly <= rnd_dly ? $urandom_range(4, 1) : fix_dly;

  always @(posedge clk) begin
    if (rst) begin
      pend_q  <= 0;
      mrvalid <= 1'b0;
      mrdata  <= 32'h0;
    end else if (mem_req && gnt_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we && mem_be[i]) mem[mem_addr[7:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
      pend_d <= mem[mem_addr[7:0]];
      if (nxt_dly <= 1) begin
        mrvalid <= 1'b1;
        mrdata  <= mem[mem_addr[7:0]];
        pend_q  <= 0;
      end else begin
        mrvalid <= 1'b0;
        pend_q  <= nxt_dly - 1;
      end
    end else if (pend_q != 0) begin
      pend_q  <= pend_q - 1;
      mrvalid <= (pend_q == 1);
      mrdata  <= pend_d;
    end else begin
      mrvalid <= 1'b0;
    end
  end

  // Grant log and response pulse counter.
  logic [29:0] log_addr [0:63];
  logic [3:0]  log_be   [0:63];
  logic [31:0] log_wd   [0:63];
  logic        log_we   [0:63];
  logic [5:0]  n_gnt = 6'd0;
  int          n_resp = 0;

  always @(posedge clk) begin
    n_resp <= n_resp + int'(resp_valid);
    if (!rst && mem_req && gnt_en) begin
      log_addr[n_gnt] <= mem_addr;
      log_be[n_gnt]   <= mem_be;
      log_wd[n_gnt]   <= mem_wdata;
      log_we[n_gnt]   <= mem_we;
      n_gnt           <= n_gnt + 6'd1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, return response fields and latency (1 = visible right after accept edge).
  task automatic do_req(input logic w, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int k;
    k = 0;
    while (!req_ready && k < 100) begin @(posedge clk); #1; k++; end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1; req_write = w; f3 = fn; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; f3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    lat = 1;
    while (!resp_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) chk("resp_timeout", 32'd0, 32'd1);
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [5:0]  g;
  int          r0, bad, k;
  logic [29:0] a0;
  logic [3:0]  b0;
  logic [31:0] w0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_memreq", 32'(mem_req), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);

    // Aligned word load
    do_req(1'b1, F3_W, 32'h100, 32'hDEADBEEF, rd, er, lat);
    g = n_gnt;
    do_req(1'b0, F3_W, 32'h100, 32'h0, rd, er, lat);
    chk("lw_addr", 32'(log_addr[g]), 32'h40);
    chk("lw_be", 32'(log_be[g]), 32'hF);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_err", 32'(er), 32'd0);

    // Sub-word loads and extension
    do_req(1'b1, F3_W, 32'h200, 32'h80FF7F01, rd, er, lat);
    do_req(1'b0, F3_B, 32'h202, 32'h0, rd, er, lat);  chk("lb", rd, 32'hFFFFFFFF);
    do_req(1'b0, F3_BU, 32'h202, 32'h0, rd, er, lat); chk("lbu", rd, 32'h000000FF);
    do_req(1'b0, F3_H, 32'h202, 32'h0, rd, er, lat);  chk("lh", rd, 32'hFFFF80FF);
    do_req(1'b0, F3_HU, 32'h200, 32'h0, rd, er, lat); chk("lhu", rd, 32'h00007F01);

    // Split store and read-back
    g = n_gnt;
    do_req(1'b1, F3_W, 32'h301, 32'h11223344, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd5);
    chk("sw_rdata", rd, 32'h0);
    chk("sw0_addr", 32'(log_addr[g]), 32'hC0);
    chk("sw0_be", 32'(log_be[g]), 32'hE);
    chk("sw0_wd", log_wd[g], 32'h22334400);
    chk("sw0_we", 32'(log_we[g]), 32'd1);
    chk("sw1_addr", 32'(log_addr[g+6'd1]), 32'hC1);
    chk("sw1_be", 32'(log_be[g+6'd1]), 32'h1);
    chk("sw1_wd", log_wd[g+6'd1], 32'h00000011);
    g = n_gnt;
    do_req(1'b0, F3_W, 32'h301, 32'h0, rd, er, lat);
    chk("lw_split", rd, 32'h11223344);
    chk("lw_split_n", 32'(n_gnt - g), 32'd2);

    // Illegal funct3 and refused misaligned access
    g = n_gnt;
    do_req(1'b0, 3'b011, 32'h40, 32'h0, rd, er, lat);
    chk("f3_011_err", 32'(er), 32'd1);
    chk("f3_011_lat", 32'(lat), 32'd1);
    chk("f3_011_rd", rd, 32'h0);
    do_req(1'b1, F3_BU, 32'h40, 32'h55, rd, er, lat);
    chk("st_f3_100_err", 32'(er), 32'd1);
    chk("err_nomem", 32'(n_gnt - g), 32'd0);
    na_valid = 1'b1; na_f3 = F3_H; na_addr = 32'h3;
    @(posedge clk); #1;
    na_valid = 1'b0;
    chk("na_resp", 32'(na_rvalid), 32'd1);
    chk("na_err", 32'(na_err), 32'd1);
    chk("na_memreq", 32'(na_mreq), 32'd0);
    @(posedge clk); #1;
    chk("na_pulse", 32'(na_rvalid), 32'd0);
    chk("na_ready", 32'(na_ready), 32'd1);

    // Grant held low, then random rvalid delays
    gnt_en = 1'b0;
    r0 = n_resp;
    req_valid = 1'b1; req_write = 1'b0; f3 = F3_W; addr = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0; addr = 32'h0;
    a0 = mem_addr; b0 = mem_be; w0 = mem_wdata;
    chk("hold_req", 32'(mem_req), 32'd1);
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!mem_req || mem_addr !== a0 || mem_be !== b0 || mem_wdata !== w0) bad++;
    end
    chk("hold_stable", 32'(bad), 32'd0);
    gnt_en = 1'b1;
    rnd_dly = 1'b1;
    k = 0;
    while (!resp_valid && k < 60) begin @(posedge clk); #1; k++; end
    chk("hold_data", resp_rdata, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_one_pulse", 32'(n_resp - r0), 32'd1);

    do_req(1'b1, F3_W, 32'hFFFFFFFC, 32'hA1B2C3D4, rd, er, lat);
    do_req(1'b1, F3_W, 32'h00000000, 32'h55667788, rd, er, lat);
    g = n_gnt;
    do_req(1'b0, F3_W, 32'hFFFFFFFD, 32'h0, rd, er, lat);
    chk("wrap_data", rd, 32'h88A1B2C3);
    chk("wrap_addr0", 32'(log_addr[g]), 32'h3FFFFFFF);
    chk("wrap_addr1", 32'(log_addr[g+6'd1]), 32'h0);
    chk("wrap_be1", 32'(log_be[g+6'd1]), 32'h1);

    // Reset during second-word wait of a split store
    rnd_dly = 1'b0;
    fix_dly = 4;
    r0 = n_resp;
    g = n_gnt;
    req_valid = 1'b1; req_write = 1'b1; f3 = F3_W; addr = 32'hE6; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; addr = 32'h0; wdata = 32'h0;
    k = 0;
    while (n_gnt != g + 6'd2 && k < 60) begin @(posedge clk); #1; k++; end
    chk("rst_mid_reached", 32'(n_gnt - g), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_memreq", 32'(mem_req), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mid_noresp", 32'(n_resp - r0), 32'd0);
    fix_dly = 1;
    do_req(1'b0, F3_W, 32'h100, 32'h0, rd, er, lat);
    chk("post_rst_data", rd, 32'hDEADBEEF);
    chk("post_rst_lat", 32'(lat), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
